// File: rtl/types_amba_pkg.sv
// Shared bus types for the memory arbiter: request/response beats and arbiter state.
package types_amba_pkg;

    localparam int CFG_SYSBUS_ADDR_BITS  = 48;
    localparam int CFG_SYSBUS_DATA_BITS  = 64;
    localparam int CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;

    typedef struct packed {
        logic [CFG_SYSBUS_ADDR_BITS-1:0]  addr;
        logic                             write;
        logic [CFG_SYSBUS_DATA_BITS-1:0]  wdata;
        logic [CFG_SYSBUS_DATA_BYTES-1:0] wstrb;
        logic                             last;
    } mem_req_type;

    typedef struct packed {
        logic [CFG_SYSBUS_DATA_BITS-1:0] rdata;
        logic                            err;
    } mem_resp_type;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_type;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       rr_last_i,
    output logic       any_o,
    output logic       winner_o
);

    assign any_o = |valid_i;

    always_comb begin
        winner_o = 1'b0;
        case (valid_i)
            2'b01:   winner_o = 1'b0;
            2'b10:   winner_o = 1'b1;
            2'b11:   winner_o = ~rr_last_i;
            default: winner_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with 1-cycle read latency.
// Optional AXI_MEM_ARB_OOR_ERR_EN: beats above the RAM window skip the RAM and answer with err.
//
//  state | meaning
//  IDLE  | no grant; picks a winner from the valid requesters
//  OWN   | owner_q holds the grant until its beat with last=1 is accepted
import types_amba_pkg::*;

module axi_mem_arbiter #(
    parameter int abits = 18,
    parameter int dbits = CFG_SYSBUS_DATA_BITS
) (
    input  logic                            i_clk,
    input  logic                            i_nrst,
    input  logic                            i_m0_req_valid,
    output logic                            o_m0_req_ready,
    input  logic [CFG_SYSBUS_ADDR_BITS-1:0] i_m0_req_addr,
    input  logic                            i_m0_req_write,
    input  logic [dbits-1:0]                i_m0_req_wdata,
    input  logic [dbits/8-1:0]              i_m0_req_wstrb,
    input  logic                            i_m0_req_last,
    output logic                            o_m0_resp_valid,
    output logic [dbits-1:0]                o_m0_resp_rdata,
    output logic                            o_m0_resp_err,
    input  logic                            i_m1_req_valid,
    output logic                            o_m1_req_ready,
    input  logic [CFG_SYSBUS_ADDR_BITS-1:0] i_m1_req_addr,
    input  logic                            i_m1_req_write,
    input  logic [dbits-1:0]                i_m1_req_wdata,
    input  logic [dbits/8-1:0]              i_m1_req_wstrb,
    input  logic                            i_m1_req_last,
    output logic                            o_m1_resp_valid,
    output logic [dbits-1:0]                o_m1_resp_rdata,
    output logic                            o_m1_resp_err,
    output logic                            o_mem_cs,
    output logic                            o_mem_we,
    output logic [abits-1:0]                o_mem_addr,
    output logic [dbits/8-1:0]              o_mem_wstrb,
    output logic [dbits-1:0]                o_mem_wdata,
    input  logic [dbits-1:0]                i_mem_rdata
);

    arb_state_type state_q, state_d;
    logic          owner_q, owner_d;
    logic          rr_last_q, rr_last_d;
    logic          resp_owner_q, resp_owner_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_read_q, resp_read_d;
    logic          resp_err_q, resp_err_d;

    mem_req_type   req [2];
    mem_req_type   sel;
    mem_resp_type  resp;
    logic [1:0]    valid;
    logic [1:0]    ready;
    logic          any_valid;
    logic          winner;
    logic          accept;
    logic          oor;
    logic          mem_cs;
    logic          mem_we;

    assign valid  = {i_m1_req_valid, i_m0_req_valid};
    assign req[0] = '{addr: i_m0_req_addr, write: i_m0_req_write, wdata: i_m0_req_wdata,
                      wstrb: i_m0_req_wstrb, last: i_m0_req_last};
    assign req[1] = '{addr: i_m1_req_addr, write: i_m1_req_write, wdata: i_m1_req_wdata,
                      wstrb: i_m1_req_wstrb, last: i_m1_req_last};
    assign sel    = req[owner_q];

    rr_arb2 u_rr_arb2 (
        .valid_i   (valid),
        .rr_last_i (rr_last_q),
        .any_o     (any_valid),
        .winner_o  (winner)
    );

`ifdef AXI_MEM_ARB_OOR_ERR_EN
    assign oor = |sel.addr[CFG_SYSBUS_ADDR_BITS-1:abits];
`else
    // Upper address bits alias onto the RAM window.
    logic unused_addr_hi;
    assign unused_addr_hi = ^sel.addr[CFG_SYSBUS_ADDR_BITS-1:abits];
    assign oor = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_last_d    = rr_last_q;
        ready        = 2'b00;
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = OWN;
                    owner_d = winner;
                end
            end
            OWN: begin
                ready[owner_q] = 1'b1;
                if (valid[owner_q]) begin
                    accept = 1'b1;
                    if (sel.last) begin
                        state_d   = IDLE;
                        rr_last_d = owner_q;
                    end
                end
            end
        endcase
        resp_valid_d = accept;
        resp_owner_d = accept ? owner_q : resp_owner_q;
        resp_read_d  = accept & ~sel.write & ~oor;
        resp_err_d   = accept & oor;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            rr_last_q    <= 1'b1;
            resp_owner_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_read_q  <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_last_q    <= rr_last_d;
            resp_owner_q <= resp_owner_d;
            resp_valid_q <= resp_valid_d;
            resp_read_q  <= resp_read_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign mem_cs      = accept & ~oor;
    assign mem_we      = mem_cs & sel.write;
    assign o_mem_cs    = mem_cs;
    assign o_mem_we    = mem_we;
    assign o_mem_addr  = mem_cs ? sel.addr[abits-1:0] : '0;
    assign o_mem_wstrb = mem_we ? sel.wstrb : '0;
    assign o_mem_wdata = mem_we ? sel.wdata : '0;

    assign o_m0_req_ready = ready[0];
    assign o_m1_req_ready = ready[1];

    // Read data comes straight from the RAM port, one cycle after the access.
    assign resp.rdata = resp_read_q ? i_mem_rdata : '0;
    assign resp.err   = resp_err_q;

    assign o_m0_resp_valid = resp_valid_q & ~resp_owner_q;
    assign o_m1_resp_valid = resp_valid_q & resp_owner_q;
    assign o_m0_resp_rdata = o_m0_resp_valid ? resp.rdata : '0;
    assign o_m1_resp_rdata = o_m1_resp_valid ? resp.rdata : '0;
    assign o_m0_resp_err   = o_m0_resp_valid & resp.err;
    assign o_m1_resp_err   = o_m1_resp_valid & resp.err;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Bench for axi_mem_arbiter: directed table, hand sequences and a random run against a memory model.
module tb_axi_mem_arbiter;

`ifdef AXI_MEM_ARB_OOR_ERR_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    logic        clk;
    logic        i_nrst;
    logic        i_m0_req_valid, i_m0_req_write, i_m0_req_last;
    logic [47:0] i_m0_req_addr;
    logic [63:0] i_m0_req_wdata;
    logic [7:0]  i_m0_req_wstrb;
    logic        i_m1_req_valid, i_m1_req_write, i_m1_req_last;
    logic [47:0] i_m1_req_addr;
    logic [63:0] i_m1_req_wdata;
    logic [7:0]  i_m1_req_wstrb;
    logic        o_m0_req_ready, o_m0_resp_valid, o_m0_resp_err;
    logic        o_m1_req_ready, o_m1_resp_valid, o_m1_resp_err;
    logic [63:0] o_m0_resp_rdata, o_m1_resp_rdata;
    logic        o_mem_cs, o_mem_we;
    logic [17:0] o_mem_addr;
    logic [7:0]  o_mem_wstrb;
    logic [63:0] o_mem_wdata;
    bit   [63:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    axi_mem_arbiter dut (
        .i_clk(clk), .i_nrst(i_nrst),
        .i_m0_req_valid(i_m0_req_valid), .o_m0_req_ready(o_m0_req_ready),
        .i_m0_req_addr(i_m0_req_addr), .i_m0_req_write(i_m0_req_write),
        .i_m0_req_wdata(i_m0_req_wdata), .i_m0_req_wstrb(i_m0_req_wstrb),
        .i_m0_req_last(i_m0_req_last), .o_m0_resp_valid(o_m0_resp_valid),
        .o_m0_resp_rdata(o_m0_resp_rdata), .o_m0_resp_err(o_m0_resp_err),
        .i_m1_req_valid(i_m1_req_valid), .o_m1_req_ready(o_m1_req_ready),
        .i_m1_req_addr(i_m1_req_addr), .i_m1_req_write(i_m1_req_write),
        .i_m1_req_wdata(i_m1_req_wdata), .i_m1_req_wstrb(i_m1_req_wstrb),
        .i_m1_req_last(i_m1_req_last), .o_m1_resp_valid(o_m1_resp_valid),
        .o_m1_resp_rdata(o_m1_resp_rdata), .o_m1_resp_err(o_m1_resp_err),
        .o_mem_cs(o_mem_cs), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wstrb(o_mem_wstrb), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: byte-masked write, registered read.
    bit [63:0] ram [32768];
    always @(posedge clk) begin
        if (o_mem_cs) begin
            if (o_mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (o_mem_wstrb[b]) ram[o_mem_addr[17:3]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[o_mem_addr[17:3]];
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int x, input logic v, input logic [47:0] a, input logic wr,
                         input logic [63:0] wd, input logic [7:0] ws, input logic l);
        if (x == 0) begin
            i_m0_req_valid = v; i_m0_req_addr = a; i_m0_req_write = wr;
            i_m0_req_wdata = wd; i_m0_req_wstrb = ws; i_m0_req_last = l;
        end else begin
            i_m1_req_valid = v; i_m1_req_addr = a; i_m1_req_write = wr;
            i_m1_req_wdata = wd; i_m1_req_wstrb = ws; i_m1_req_last = l;
        end
    endtask

    function automatic logic rdy(input int x);
        return (x == 0) ? o_m0_req_ready : o_m1_req_ready;
    endfunction
    function automatic logic rv(input int x);
        return (x == 0) ? o_m0_resp_valid : o_m1_resp_valid;
    endfunction
    function automatic logic er(input int x);
        return (x == 0) ? o_m0_resp_err : o_m1_resp_err;
    endfunction
    function automatic logic [63:0] rd(input int x);
        return (x == 0) ? o_m0_resp_rdata : o_m1_resp_rdata;
    endfunction

    function automatic logic [127:0] all_out();
        return {91'b0, o_m0_req_ready, o_m1_req_ready, o_m0_resp_valid, o_m1_resp_valid,
                o_m0_resp_err, o_m1_resp_err, o_mem_cs, o_mem_we, o_mem_wstrb, o_mem_addr,
                |o_m0_resp_rdata, |o_m1_resp_rdata, |o_mem_wdata};
    endfunction

    task automatic idle_inputs();
        drive(0, 1'b0, 48'h0, 1'b0, 64'h0, 8'h0, 1'b0);
        drive(1, 1'b0, 48'h0, 1'b0, 64'h0, 8'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_nrst = 1'b0;
        idle_inputs();
        @(negedge clk);
        i_nrst = 1'b1;
    endtask

    // Single-beat transaction starting from IDLE: idle cycle, accept cycle, response cycle.
    task automatic beat_solo(input int x, input logic [47:0] a, input logic wr, input logic [63:0] wd,
                             input logic [7:0] ws, input logic exp_cs, input logic [63:0] exp_rd,
                             input logic exp_err);
        @(negedge clk);
        drive(x, 1'b1, a, wr, wd, ws, 1'b1);
        #1;
        check("solo_idle_rdy", 128'(rdy(x)), 128'(1'b0));
        @(negedge clk);
        #1;
        check("solo_accept", 128'({rdy(x), o_mem_cs, o_mem_we, exp_cs ? o_mem_addr : 18'h0}),
              128'({1'b1, exp_cs, exp_cs & wr, exp_cs ? a[17:0] : 18'h0}));
        @(negedge clk);
        drive(x, 1'b0, a, wr, wd, ws, 1'b0);
        #1;
        check("solo_resp", 128'({rv(x), er(x), rd(x)}), 128'({1'b1, exp_err, exp_rd}));
    endtask

    typedef struct {
        logic v0, l0, v1, l1;
        logic r0, r1, cs, we, rv0, rv1;
    } vec_t;

    // Random stimulus state and reference model.
    int          b_left [2];
    logic        b_v    [2];
    logic [47:0] b_addr [2];
    logic        b_wr   [2];
    logic [63:0] b_wd   [2];
    logic [7:0]  b_ws   [2];
    int          m_gnt;
    int          m_lastw;
    logic        e_rv [2];
    logic        e_er [2];
    logic [63:0] e_rd [2];
    bit   [63:0] ref_mem [32768];

    function automatic logic [47:0] rand_addr();
        logic [47:0] a;
        a = 48'h1000 + 48'($urandom_range(0, 63)) * 48'd8;
        if ($urandom_range(0, 7) == 0) a[47:18] = 30'($urandom_range(1, 1000));
        return a;
    endfunction

    task automatic new_beat(input int x);
        b_addr[x] = rand_addr();
        b_wr[x]   = 1'($urandom_range(0, 1));
        b_wd[x]   = {$urandom, $urandom};
        b_ws[x]   = 8'($urandom);
    endtask

    initial begin
        vec_t tbl [17];
        logic [1:0]  acc;
        logic        oor, e_cs, e_we;
        logic [17:0] e_addr;
        logic [7:0]  e_ws;
        logic [63:0] e_wd;
        int          g;

        tbl[0]  = '{1,0,1,0, 0,0,0,0,0,0};
        tbl[1]  = '{1,0,1,0, 1,0,1,0,0,0};
        tbl[2]  = '{1,1,1,0, 1,0,1,0,1,0};
        tbl[3]  = '{0,0,1,0, 0,0,0,0,1,0};
        tbl[4]  = '{1,0,1,0, 0,1,1,1,0,0};
        tbl[5]  = '{1,0,1,0, 0,1,1,1,0,1};
        tbl[6]  = '{1,0,0,0, 0,1,0,0,0,1};
        tbl[7]  = '{1,0,1,0, 0,1,1,1,0,0};
        tbl[8]  = '{1,0,1,1, 0,1,1,1,0,1};
        tbl[9]  = '{1,0,0,0, 0,0,0,0,0,1};
        tbl[10] = '{1,1,0,0, 1,0,1,0,0,0};
        tbl[11] = '{0,0,0,0, 0,0,0,0,1,0};
        tbl[12] = '{1,0,1,0, 0,0,0,0,0,0};
        tbl[13] = '{1,0,1,1, 0,1,1,1,0,0};
        tbl[14] = '{1,1,0,0, 0,0,0,0,0,1};
        tbl[15] = '{1,1,0,0, 1,0,1,0,0,0};
        tbl[16] = '{0,0,0,0, 0,0,0,0,1,0};

        // Reset state, with both requesters pushing.
        i_nrst = 1'b0;
        drive(0, 1'b1, 48'h40, 1'b1, 64'h1, 8'hFF, 1'b1);
        drive(1, 1'b1, 48'h80, 1'b1, 64'h2, 8'hFF, 1'b1);
        @(negedge clk);
        #1;
        check("reset_state", all_out(), 128'h0);
        idle_inputs();
        i_nrst = 1'b1;

        // Contention, burst hold with a valid gap, and round-robin turnover.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(0, tbl[i].v0, 48'h300, 1'b0, 64'h0, 8'hFF, tbl[i].l0);
            drive(1, tbl[i].v1, 48'h200, 1'b1, 64'hDEAD_BEEF_0000_0000 + 64'(i), 8'hFF, tbl[i].l1);
            #1;
            check($sformatf("table_row%0d", i),
                  128'({o_m0_req_ready, o_m1_req_ready, o_mem_cs, o_mem_we, o_m0_resp_valid, o_m1_resp_valid}),
                  128'({tbl[i].r0, tbl[i].r1, tbl[i].cs, tbl[i].we, tbl[i].rv0, tbl[i].rv1}));
        end

        // Solo write/read, byte strobes, and an address above the RAM window.
        beat_solo(0, 48'h40, 1'b1, 64'h1122334455667788, 8'hFF, 1'b1, 64'h0, 1'b0);
        beat_solo(0, 48'h40, 1'b0, 64'h0, 8'h00, 1'b1, 64'h1122334455667788, 1'b0);
        beat_solo(1, 48'h80, 1'b1, 64'h1122334455667788, 8'hFF, 1'b1, 64'h0, 1'b0);
        beat_solo(1, 48'h80, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1, 64'h0, 1'b0);
        beat_solo(0, 48'h80, 1'b0, 64'h0, 8'h00, 1'b1, 64'h11223344FFFFFFFF, 1'b0);
        beat_solo(1, 48'h0, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 1'b1, 64'h0, 1'b0);
        beat_solo(0, 48'h40000, 1'b0, 64'h0, 8'h00, !OOR_EN,
                  OOR_EN ? 64'h0 : 64'hA5A5_5A5A_0F0F_F0F0, OOR_EN);

        // Reset in the middle of a 4-beat burst.
        do_reset();
        @(negedge clk);
        drive(1, 1'b1, 48'h400, 1'b1, 64'h101, 8'hFF, 1'b0);
        @(negedge clk);
        #1;
        check("rmb_beat1", 128'({o_m1_req_ready, o_mem_cs}), 128'(2'b11));
        @(negedge clk);
        drive(1, 1'b1, 48'h408, 1'b1, 64'h102, 8'hFF, 1'b0);
        #1;
        check("rmb_beat2", 128'({o_m1_req_ready, o_mem_cs}), 128'(2'b11));
        @(negedge clk);
        drive(1, 1'b1, 48'h410, 1'b1, 64'h103, 8'hFF, 1'b0);
        #1;
        check("rmb_resp_pending", 128'(o_m1_resp_valid), 128'(1'b1));
        i_nrst = 1'b0;
        #1;
        check("rmb_async_clear", all_out(), 128'h0);
        @(negedge clk);
        #1;
        check("rmb_hold", all_out(), 128'h0);
        idle_inputs();
        i_nrst = 1'b1;
        @(negedge clk);
        drive(1, 1'b1, 48'h418, 1'b1, 64'h104, 8'hFF, 1'b1);
        #1;
        check("rmb_no_stray", 128'({o_m1_req_ready, o_m0_resp_valid, o_m1_resp_valid}), 128'(3'b000));
        @(negedge clk);
        idle_inputs();

        // Random traffic against the reference model.
        do_reset();
        m_gnt = -1;
        m_lastw = 1;
        for (int x = 0; x < 2; x++) begin
            b_left[x] = 0; b_v[x] = 1'b0; e_rv[x] = 1'b0; e_er[x] = 1'b0; e_rd[x] = 64'h0;
            new_beat(x);
        end
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            for (int x = 0; x < 2; x++) begin
                if (b_left[x] == 0 && $urandom_range(0, 2) == 0) begin
                    b_left[x] = $urandom_range(1, 4);
                    new_beat(x);
                end
                b_v[x] = (b_left[x] != 0) && ($urandom_range(0, 4) != 0);
                drive(x, b_v[x], b_addr[x], b_wr[x], b_wd[x], b_ws[x], b_left[x] == 1);
            end
            #1;
            acc[0] = (m_gnt == 0) && b_v[0];
            acc[1] = (m_gnt == 1) && b_v[1];
            check("rnd_ready", 128'({o_m0_req_ready, o_m1_req_ready}), 128'({m_gnt == 0, m_gnt == 1}));
            for (int x = 0; x < 2; x++)
                check(x == 0 ? "rnd_resp0" : "rnd_resp1",
                      128'({rv(x), e_rv[x] ? er(x) : 1'b0, e_rv[x] ? rd(x) : 64'h0}),
                      128'({e_rv[x], e_er[x], e_rd[x]}));

            e_cs = 1'b0; e_we = 1'b0; e_addr = 18'h0; e_ws = 8'h0; e_wd = 64'h0;
            for (int x = 0; x < 2; x++) begin
                e_rv[x] = acc[x]; e_er[x] = 1'b0; e_rd[x] = 64'h0;
                if (acc[x]) begin
                    oor = OOR_EN && (b_addr[x][47:18] != 30'h0);
                    e_er[x] = oor;
                    if (!oor) begin
                        e_cs = 1'b1;
                        e_addr = b_addr[x][17:0];
                        if (b_wr[x]) begin
                            e_we = 1'b1; e_ws = b_ws[x]; e_wd = b_wd[x];
                            for (int b = 0; b < 8; b++)
                                if (b_ws[x][b]) ref_mem[b_addr[x][17:3]][8*b +: 8] = b_wd[x][8*b +: 8];
                        end else begin
                            e_rd[x] = ref_mem[b_addr[x][17:3]];
                        end
                    end
                end
            end
            check("rnd_mem", 128'({o_mem_cs, o_mem_we, o_mem_wstrb, e_cs ? o_mem_addr : 18'h0,
                                   e_we ? o_mem_wdata : 64'h0}),
                  128'({e_cs, e_we, e_ws, e_addr, e_wd}));

            g = m_gnt;
            if (g < 0) begin
                if (b_v[0] && b_v[1]) m_gnt = 1 - m_lastw;
                else if (b_v[0])      m_gnt = 0;
                else if (b_v[1])      m_gnt = 1;
            end else if (acc[g] && b_left[g] == 1) begin
                m_lastw = g;
                m_gnt = -1;
            end
            for (int x = 0; x < 2; x++) begin
                if (b_v[x] && rdy(x)) begin
                    b_left[x]--;
                    if (b_left[x] != 0) new_beat(x);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
